// File: rtl/jedro_1_pkg.sv
// jedro_1_pkg: shared widths and clear-FSM state encoding for the jedro_1 register file
package jedro_1_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;
endpackage

// File: rtl/jedro_1_regfile_rdport.sv
// jedro_1_regfile_rdport: one registered read port with zero-register mask and write bypass
module jedro_1_regfile_rdport import jedro_1_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] arr_data_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [DATA_WIDTH-1:0] data_q, data_d;
  // wr_en_i is the accepted user write only, so clear-engine writes never bypass
  always_comb begin
    data_d = !en_i ? data_q :
             (ZERO_REG && addr_i == '0) ? '0 :
             (BYPASS && wr_en_i && wr_addr_i == addr_i) ? wr_data_i : arr_data_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else data_q <= data_d;
  end
  assign data_o = data_q;
endmodule

// File: rtl/jedro_1_regfile_mp.sv
// jedro_1_regfile_mp: multi-read-port register file with one write port and a sequential clear engine
module jedro_1_regfile_mp import jedro_1_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_RD-1:0]            rd_en_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  input  logic                         wr_en_i,
  input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic                         clr_req_i,
  output logic                         busy_o,
  output logic                         clr_done_o
);
  localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;
  clr_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic wr_ok;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // the last clear slot is the all-ones counter value
  always_comb begin
    state_d = (state_q == IDLE && clr_req_i) ? CLEAR :
              (state_q == CLEAR && &cnt_q) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
    cnt_d = (state_q == CLEAR) ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    busy_o = state_q == CLEAR;
    clr_done_o = state_q == DONE;
  end
  assign wr_ok = wr_en_i && !busy_o && !(ZERO_REG && wr_addr_i == '0);
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr_i] = wr_data_i;
    if (busy_o) mem_d[cnt_q] = '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    jedro_1_regfile_rdport #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS(BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_i(rd_en_i[k]),
      .addr_i(rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .arr_data_i(mem_q[rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]]),
      .wr_en_i(wr_ok),
      .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i),
      .data_o(rd_data_o[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_jedro_1_regfile_mp.sv
// tb_jedro_1_regfile_mp: directed table-driven bench; dut a has bypass+zero-reg, dut b has neither
module tb_jedro_1_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] re;
  logic [4:0] ra0, ra1;
  logic we, clr_req;
  logic [4:0] wa;
  logic [31:0] wd;
  logic [63:0] rd_a, rd_b;
  logic busy_a, busy_b, done_a, done_b;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  jedro_1_regfile_mp u_a (
    .clk_i(clk), .rst_i(rst), .rd_en_i(re), .rd_addr_i({ra1, ra0}), .rd_data_o(rd_a),
    .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd), .clr_req_i(clr_req),
    .busy_o(busy_a), .clr_done_o(done_a)
  );
  jedro_1_regfile_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .rd_en_i(re), .rd_addr_i({ra1, ra0}), .rd_data_o(rd_b),
    .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd), .clr_req_i(clr_req),
    .busy_o(busy_b), .clr_done_o(done_b)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  typedef struct {
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [1:0] re;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic [31:0] ea0;
    logic [31:0] ea1;
    logic [31:0] eb0;
    logic [31:0] eb1;
  } vec_t;
  vec_t v [13];
  int busy_n, done_n, done_at;
  initial begin
    v[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[1]  = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    v[2]  = '{1'b1, 5'd7, 32'h12345678, 2'b01, 5'd7, 5'd0, 32'h12345678, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    v[3]  = '{1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    v[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 2'b00, 5'd0, 5'd0, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    v[5]  = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    v[6]  = '{1'b1, 5'd0, 32'h11111111, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    v[7]  = '{1'b1, 5'd2, 32'h55, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    v[8]  = '{1'b0, 5'd0, 32'h0, 2'b01, 5'd2, 5'd0, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF};
    v[9]  = '{1'b1, 5'd2, 32'h66, 2'b00, 5'd2, 5'd0, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF};
    v[10] = '{1'b0, 5'd0, 32'h0, 2'b00, 5'd2, 5'd5, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF};
    v[11] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd2, 5'd5, 32'h66, 32'hDEADBEEF, 32'h66, 32'hDEADBEEF};
    v[12] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 32'h11111111, 32'h11111111};
    rst = 1'b1; re = '0; ra0 = '0; ra1 = '0; we = 1'b0; wa = '0; wd = '0; clr_req = 1'b0;
    #1;
    chk("reset_rd_a", rd_a, 64'h0);
    chk("reset_rd_b", rd_b, 64'h0);
    chk("reset_busy", {63'h0, busy_a}, 64'h0);
    chk("reset_done", {63'h0, done_a}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      we = v[i].we; wa = v[i].wa; wd = v[i].wd; re = v[i].re; ra0 = v[i].ra0; ra1 = v[i].ra1;
      @(negedge clk);
      chk($sformatf("vec%0d_a_p0", i), {32'h0, rd_a[31:0]}, {32'h0, v[i].ea0});
      chk($sformatf("vec%0d_a_p1", i), {32'h0, rd_a[63:32]}, {32'h0, v[i].ea1});
      chk($sformatf("vec%0d_b_p0", i), {32'h0, rd_b[31:0]}, {32'h0, v[i].eb0});
      chk($sformatf("vec%0d_b_p1", i), {32'h0, rd_b[63:32]}, {32'h0, v[i].eb1});
    end
    we = 1'b0; re = '0;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i);
      @(negedge clk);
    end
    we = 1'b0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) busy_n++;
      if (done_a) begin done_n++; done_at = i; end
      if (i == 1) begin
        chk("clear_live_read_a", {32'h0, rd_a[31:0]}, 64'd31);
        chk("clear_live_read_b", {32'h0, rd_b[31:0]}, 64'd31);
        re = '0;
      end
      if (i == 11) we = 1'b0;
      if (i == 0) begin re = 2'b01; ra0 = 5'd31; end
      if (i == 10) begin we = 1'b1; wa = 5'd3; wd = 32'hAA; end
      @(negedge clk);
    end
    chk("busy_cycles", 64'(busy_n), 64'd32);
    chk("done_pulses", 64'(done_n), 64'd1);
    chk("done_position", 64'(done_at), 64'd32);
    for (int r = 0; r < 32; r++) begin
      re = 2'b11; ra0 = 5'(r); ra1 = 5'(r);
      @(negedge clk);
      chk($sformatf("cleared_x%0d_a", r), {32'h0, rd_a[31:0]}, 64'h0);
      chk($sformatf("cleared_x%0d_b", r), {32'h0, rd_b[63:32]}, 64'h0);
    end
    re = '0;
    we = 1'b1; wa = 5'd4; wd = 32'h44;
    @(negedge clk);
    wa = 5'd9; wd = 32'h99;
    @(negedge clk);
    we = 1'b0; re = 2'b01; ra0 = 5'd4;
    @(negedge clk);
    chk("pre_abort_read_a", rd_a, 64'h44);
    chk("pre_abort_read_b", rd_b, 64'h44);
    re = '0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", {63'h0, busy_a}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy_a", {63'h0, busy_a}, 64'h0);
    chk("abort_busy_b", {63'h0, busy_b}, 64'h0);
    chk("abort_rd_a", rd_a, 64'h0);
    chk("abort_rd_b", rd_b, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_a || done_b || busy_a) done_n++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(done_n), 64'h0);
    re = 2'b11; ra0 = 5'd4; ra1 = 5'd9;
    @(negedge clk);
    re = '0;
    chk("abort_regs_a", rd_a, 64'h0);
    chk("abort_regs_b", rd_b, 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
